mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// In-order load/store responder over a banked RAM/ROM map, with a small response FIFO.
// Optional sticky ROM-store flag is built only when MEMRESP_ERR_EN is defined.
module mem_responder #(
   parameter int RSP_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [11:0] req_addr,
   input  logic [14:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [14:0] rsp_data,
   output logic [14:0] rom_addr,
   input  logic [14:0] rom_rdata,
   output logic [10:0] ram_addr,
   output logic        ram_we,
   output logic [14:0] ram_wdata,
   input  logic [14:0] ram_rdata,
   output logic        err_rom_write
);
   localparam int               PTR_W    = (RSP_DEPTH > 2) ? 2 : 1;
   localparam logic [2:0]       DEPTH_C  = 3'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

   typedef enum logic [1:0] {SRC_RAM, SRC_ROM, SRC_REG} src_e;

   logic [2:0]       eb_q, eb_d;
   logic [4:0]       fb_q, fb_d;
   logic             vld_p1_q, vld_p1_d;
   src_e             src_p1_q, src_p1_d;
   logic [14:0]      regval_p1_q, regval_p1_d;
   logic [14:0]      fifo_q [RSP_DEPTH];
   logic [14:0]      fifo_d [RSP_DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [2:0]       cnt_q, cnt_d;

   logic             accept, is_eb, is_fb, is_rom, pop, push;
   logic [2:0]       occ;
   logic [14:0]      push_data;

   // Stage 0: request decode, memory address generation and flow control
   always_comb begin
      is_eb     = (req_addr == 12'h003);
      is_fb     = (req_addr == 12'h004);
      is_rom    = req_addr[11] | req_addr[10];
      rsp_valid = !reset && (cnt_q != 3'd0);
      pop       = rsp_valid && rsp_ready;
      occ       = cnt_q + {2'b00, vld_p1_q} - {2'b00, pop};
      req_ready = !reset && (occ < DEPTH_C);
      accept    = req_valid && req_ready;
      ram_addr  = (req_addr[11:8] == 4'h3) ? {eb_q, req_addr[7:0]} : {1'b0, req_addr[9:0]};
      rom_addr  = req_addr[11] ? {4'b0001, req_addr[10:0]} : {fb_q, req_addr[9:0]};
      ram_we    = accept && req_we && !is_rom && !is_eb && !is_fb;
      ram_wdata = req_wdata;
      rsp_data  = fifo_q[rd_q];
   end

   always_comb begin
      eb_d        = eb_q;
      fb_d        = fb_q;
      vld_p1_d    = accept && !req_we;
      src_p1_d    = is_rom ? SRC_ROM : ((is_eb || is_fb) ? SRC_REG : SRC_RAM);
      regval_p1_d = is_eb ? {4'b0000, eb_q, 8'h00} : {fb_q, 10'h000};
      if (accept && req_we && is_eb) eb_d = req_wdata[10:8];
      if (accept && req_we && is_fb) fb_d = req_wdata[14:10];

      // Stage 1: memory data returns one cycle after the load was accepted
      push = vld_p1_q;
      case (src_p1_q)
         SRC_ROM: push_data = rom_rdata;
         SRC_REG: push_data = regval_p1_q;
         default: push_data = ram_rdata;
      endcase
      fifo_d = fifo_q;
      if (push) fifo_d[wr_q] = push_data;
      wr_d  = push ? ((wr_q == PTR_LAST) ? '0 : wr_q + PTR_W'(1)) : wr_q;
      rd_d  = pop  ? ((rd_q == PTR_LAST) ? '0 : rd_q + PTR_W'(1)) : rd_q;
      cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         eb_q     <= '0;
         fb_q     <= '0;
         vld_p1_q <= 1'b0;
         cnt_q    <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
      end else begin
         eb_q     <= eb_d;
         fb_q     <= fb_d;
         vld_p1_q <= vld_p1_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   // Payload registers carry no reset; the valid/count state qualifies them
   always_ff @(posedge clock) begin
      src_p1_q    <= src_p1_d;
      regval_p1_q <= regval_p1_d;
      fifo_q      <= fifo_d;
   end

`ifdef MEMRESP_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (accept & req_we & is_rom);
   end

   always_ff @(posedge clock) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err_rom_write = err_q;
`else
   assign err_rom_write = 1'b0;
`endif

endmodule
